seg7_scan_decoder: RTL and testbench

Drives the Basys3 four-digit seven-segment display from a 16-bit hex value. A refresh counter advances a 2-bit digit index, and the index is decoded 2-to-4 into one-hot active-low anode enables. The selected nibble is decoded to active-low segment patterns. New display data is loaded via a strobe and applied only at frame boundaries, so the display never shows a torn value.

---
 rtl/seg7_scan_decoder_if.sv | 11 +
 rtl/seg7_scan_decoder.sv | 110 +++++++++++
 tb/tb_seg7_scan_decoder.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_decoder_if.sv
// Load-side bus for seg7_scan_decoder: display word, strobe and pending flag.
interface seg7_scan_decoder_if;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic        load;
  logic        busy;

  modport master (output value, dp, digit_en, load, input busy);
  modport slave  (input value, dp, digit_en, load, output busy);
endinterface

// File: rtl/seg7_scan_decoder.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous data update.
// All display outputs are registered one cycle behind the cnt/idx/active state.
module seg7_scan_decoder #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seg7_scan_decoder_if.slave   bus,
  output logic [3:0]           an,
  output logic [6:0]           seg,
  output logic                 dp_n,
  output logic [1:0]           digit_sel,
  output logic                 frame_tick
);
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
  } disp_t;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  disp_t         pend, act, ld;
  logic          busy_q;
  logic          wrap, boundary, lit;
  logic [3:0]    nib, an_d;
  logic [6:0]    seg_d;

  assign ld       = {bus.value, bus.dp, bus.digit_en};
  assign wrap     = (cnt == CW'(REFRESH_DIV - 1));
  assign boundary = wrap && (idx == 2'd3);
  assign lit      = (cnt >= CW'(BLANK_CYC));
  assign bus.busy = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (wrap) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // A strobe landing on the boundary bypasses pending and takes effect this frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend   <= '0;
      act    <= '0;
      busy_q <= 1'b0;
    end else if (boundary) begin
      if (bus.load)   act <= ld;
      else if (busy_q) act <= pend;
      busy_q <= 1'b0;
    end else if (bus.load) begin
      pend   <= ld;
      busy_q <= 1'b1;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_an
    assign an_d[k] = ~((idx == 2'(k)) && lit && act.en[k]);
  end

  assign nib = act.value[{idx, 2'b00} +: 4];

  always_comb begin
    seg_d = 7'h7f;
    case (nib)
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0010000;
      4'ha: seg_d = 7'b0001000;
      4'hb: seg_d = 7'b0000011;
      4'hc: seg_d = 7'b1000110;
      4'hd: seg_d = 7'b0100001;
      4'he: seg_d = 7'b0000110;
      4'hf: seg_d = 7'b0001110;
      default: seg_d = 7'h7f;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an         <= 4'hf;
      seg        <= 7'h7f;
      dp_n       <= 1'b1;
      digit_sel  <= 2'd0;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_d;
      seg        <= seg_d;
      dp_n       <= ~act.dp[idx];
      digit_sel  <= idx;
      frame_tick <= (cnt == '0) && (idx == 2'd0);
    end
  end
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder at REFRESH_DIV=8, BLANK_CYC=2 (32-cycle frames).
module tb_seg7_scan_decoder;
  localparam int DIV   = 8;
  localparam int BLANK = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp_n;
  logic [1:0] digit_sel;
  logic       frame_tick;

  seg7_scan_decoder_if bus_if();

  seg7_scan_decoder #(.REFRESH_DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_if),
    .an(an), .seg(seg), .dp_n(dp_n), .digit_sel(digit_sel), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n     = 0;   // clock edges since reset release

  // hand-entered active-low hex font, seg[6:0] = gfedcba
  logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp_v, n);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    n++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_an"},   an,          4'hf);
    chk({tag, "_seg"},  seg,         7'h7f);
    chk({tag, "_dpn"},  dp_n,        1'b1);
    chk({tag, "_sel"},  digit_sel,   2'd0);
    chk({tag, "_tick"}, frame_tick,  1'b0);
    chk({tag, "_busy"}, bus_if.busy, 1'b0);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    bus_if.value = v; bus_if.dp = d; bus_if.digit_en = e; bus_if.load = 1'b1;
    tick();
    bus_if.load = 1'b0;
  endtask

  // Nothing lit: anodes dark, frame_tick on the first digit-0 cycle of each frame.
  task automatic run_dark(input int cyc);
    int p;
    for (int i = 0; i < cyc; i++) begin
      tick();
      p = (n - 1) % (4 * DIV);
      chk("dark_an",   an,          4'hf);
      chk("dark_tick", frame_tick,  p == 0);
      chk("dark_busy", bus_if.busy, 1'b0);
    end
  endtask

  // One full frame showing word v, starting right after a boundary edge.
  task automatic run_frame(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
    int p, k, c;
    logic [3:0] exp_an;
    logic       exp_dp;
    for (int i = 0; i < 4 * DIV; i++) begin
      tick();
      p = (n - 1) % (4 * DIV);
      k = p / DIV;
      c = p % DIV;
      exp_an = 4'hf;
      if (c >= BLANK && e[k]) exp_an[k] = 1'b0;
      exp_dp = ~d[k];
      chk("an",   an,          exp_an);
      chk("seg",  seg,         font[v[k*4 +: 4]]);
      chk("dp_n", dp_n,        exp_dp);
      chk("sel",  digit_sel,   k);
      chk("tick", frame_tick,  p == 0);
      chk("busy", bus_if.busy, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.load = 1'b0; bus_if.value = '0; bus_if.dp = '0; bus_if.digit_en = '0;
    #12;
    chk_reset("por");
    @(posedge clk); #1 rst_n = 1'b1; n = 0;

    // async reset mid-slot (digit 2), between clock edges
    while (n < 20) tick();
    chk("pre_rst_sel", digit_sel, 2'd2);
    chk("pre_rst_seg", seg, 7'b1000000);
    #2 rst_n = 1'b0;
    #1 chk_reset("async");
    @(posedge clk); #1 rst_n = 1'b1; n = 0;
    run_dark(3 * 4 * DIV);

    // basic load mid-frame, applied at boundary edge 128
    while (n < 104) tick();
    do_load(16'h1A8F, 4'b0010, 4'b1111);
    chk("basic_busy", bus_if.busy, 1'b1);
    while (n < 127) tick();
    chk("basic_busy_late", bus_if.busy, 1'b1);
    chk("basic_dark", an, 4'hf);
    tick();
    chk("basic_busy_clr", bus_if.busy, 1'b0);
    run_frame(16'h1A8F, 4'b0010, 4'b1111);

    // digit enable mask
    while (n < 170) tick();
    do_load(16'h4321, 4'b0000, 4'b0101);
    while (n < 192) tick();
    run_frame(16'h4321, 4'b0000, 4'b0101);

    // double load: last one wins, busy clears once
    while (n < 230) tick();
    do_load(16'h1111, 4'b0000, 4'b1111);
    chk("dbl_busy1", bus_if.busy, 1'b1);
    while (n < 240) tick();
    do_load(16'h2222, 4'b0000, 4'b1111);
    while (n < 255) begin
      tick();
      chk("dbl_busy", bus_if.busy, 1'b1);
    end
    tick();
    chk("dbl_busy_clr", bus_if.busy, 1'b0);
    run_frame(16'h2222, 4'b0000, 4'b1111);

    // load in the boundary cycle itself (edge 320)
    while (n < 319) tick();
    do_load(16'h00C3, 4'b1000, 4'b1111);
    chk("bnd_busy", bus_if.busy, 1'b0);
    run_frame(16'h00C3, 4'b1000, 4'b1111);

    // reset during digit 2 with a load pending
    while (n < 356) tick();
    do_load(16'h5555, 4'b1111, 4'b1111);
    while (n < 372) tick();
    chk("mid_busy", bus_if.busy, 1'b1);
    chk("mid_an",   an, 4'b1011);
    chk("mid_sel",  digit_sel, 2'd2);
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_rst");
    @(posedge clk); #1 rst_n = 1'b1; n = 0;
    run_dark(2 * 4 * DIV);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
